// File: rtl/arinc429_tx_sched_pkg.sv
// Shared types and config-address helpers for the ARINC429 periodic transmit scheduler.
package arinc429_sched_pkg;

  localparam int ENABLE_BIT       = 31;
  localparam int DEFAULT_PERIOD_W = 16;
  localparam int CFG_ADDR_W       = 5;
  localparam int SLOT_IDX_W       = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

  // Even addresses hold slot words, odd addresses hold slot controls.
  function automatic logic [SLOT_IDX_W-1:0] cfg_slot(input logic [CFG_ADDR_W-1:0] addr);
    return SLOT_IDX_W'(addr >> 1);
  endfunction

  function automatic logic cfg_is_ctl(input logic [CFG_ADDR_W-1:0] addr);
    return addr[0];
  endfunction

  function automatic logic cfg_is_word(input logic [CFG_ADDR_W-1:0] addr);
    return ~addr[0];
  endfunction

endpackage

// File: rtl/arinc429_tx_sched_if.sv
// Config / overrun / Avalon-ST source bundle of arinc429_tx_sched.
// Aperiodic signals exist only with ARINC429_TX_SCHED_APERIODIC_EN.
interface arinc429_tx_sched_if #(
  parameter int NUM_SLOTS = 8
);
  logic                 i_cfg_write;
  logic [4:0]           i_cfg_addr;
  logic [31:0]          i_cfg_wdata;
  logic                 i_ovr_clr;
  logic [NUM_SLOTS-1:0] o_overrun;
  logic                 o_src_valid;
  logic [31:0]          o_src_data;
  logic                 i_src_ready;
`ifdef ARINC429_TX_SCHED_APERIODIC_EN
  logic                 i_apr_valid;
  logic [31:0]          i_apr_data;
  logic                 o_apr_ready;

  modport master (
    output i_cfg_write, i_cfg_addr, i_cfg_wdata, i_ovr_clr, i_src_ready, i_apr_valid, i_apr_data,
    input  o_overrun, o_src_valid, o_src_data, o_apr_ready
  );
  modport slave (
    input  i_cfg_write, i_cfg_addr, i_cfg_wdata, i_ovr_clr, i_src_ready, i_apr_valid, i_apr_data,
    output o_overrun, o_src_valid, o_src_data, o_apr_ready
  );
`else
  modport master (
    output i_cfg_write, i_cfg_addr, i_cfg_wdata, i_ovr_clr, i_src_ready,
    input  o_overrun, o_src_valid, o_src_data
  );
  modport slave (
    input  i_cfg_write, i_cfg_addr, i_cfg_wdata, i_ovr_clr, i_src_ready,
    output o_overrun, o_src_valid, o_src_data
  );
`endif
endinterface

// File: rtl/arinc429_tx_sched_slot_timer.sv
// One periodic slot: enable, period, tick down-counter, pending and sticky overrun flags.
module arinc429_slot_timer
  import arinc429_sched_pkg::*;
#(
  parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                ctl_wr_i,
  input  logic                ctl_en_i,
  input  logic [PERIOD_W-1:0] ctl_period_i,
  input  logic                grant_i,
  input  logic                ovr_clr_i,
  output logic                pending_o,
  output logic                overrun_o
);

  logic                en_q, en_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                active;
  logic                due;

  // A control write overrides any due event in the same cycle; a new due event beats a grant.
  always_comb begin
    en_d   = en_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    active = en_q && (per_q != '0);
    due    = tick_i && active && (cnt_q == PERIOD_W'(1));
    if (ctl_wr_i) begin
      en_d   = ctl_en_i;
      per_d  = ctl_period_i;
      cnt_d  = ctl_period_i;
      pend_d = 1'b0;
    end else begin
      if (due) begin
        cnt_d = per_q;
      end else if (tick_i && active && (cnt_q != '0)) begin
        cnt_d = cnt_q - PERIOD_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (due) begin
        pend_d = 1'b1;
      end else if (grant_i) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end
    if (due && pend_q && !grant_i && !ctl_wr_i) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      per_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/arinc429_tx_sched.sv
// Periodic-label scheduler in front of an ARINC429 transmitter: round-robin over due slots.
// ARINC429_TX_SCHED_APERIODIC_EN adds a strict-priority aperiodic word input.
module arinc429_tx_sched
  import arinc429_sched_pkg::*;
#(
  parameter int unsigned IN_AVS_CLK = 32'd50000000,
  parameter int unsigned TICK_DIV   = IN_AVS_CLK / 32'd1000,
  parameter int          NUM_SLOTS  = 8,
  parameter int          PERIOD_W   = DEFAULT_PERIOD_W
) (
  input  logic                i_avs_clk,
  input  logic                i_avs_rst,
  arinc429_tx_sched_if.slave  bus
);

  logic [31:0]           presc_q, presc_d;
  logic                  tick;
  logic                  cfg_mapped;
  logic [SLOT_IDX_W-1:0] cfg_sel;
  logic                  word_wr;
  logic [NUM_SLOTS-1:0]  ctl_wr;
  logic [NUM_SLOTS-1:0]  pending;
  logic [NUM_SLOTS-1:0]  grant;
  logic [NUM_SLOTS-1:0]  overrun;
  logic [31:0]           word_q [NUM_SLOTS];
  logic [2*NUM_SLOTS-1:0] pend_rot;
  logic                  any_pend;
  logic                  found;
  logic [SLOT_IDX_W-1:0] pick;
  logic [SLOT_IDX_W-1:0] rr_next;
  logic [31:0]           pick_word;
  logic                  apr_take;
  logic [31:0]           apr_word;
  sched_state_e          state_q;
  logic [SLOT_IDX_W-1:0] rr_q;
  logic                  valid_q;
  logic [31:0]           data_q;

  // Millisecond prescaler; tick is the terminal-count cycle.
  always_comb begin
    tick = (presc_q == 32'(TICK_DIV - 32'd1));
    if (tick) begin
      presc_d = 32'd0;
    end else begin
      presc_d = presc_q + 32'd1;
    end
  end

  // Prescaler register.
  always_ff @(posedge i_avs_clk or posedge i_avs_rst) begin
    if (i_avs_rst) begin
      presc_q <= 32'd0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign cfg_mapped = ({27'd0, bus.i_cfg_addr} < 32'(2 * NUM_SLOTS));
  assign cfg_sel    = cfg_slot(bus.i_cfg_addr);
  assign word_wr    = bus.i_cfg_write && cfg_mapped && cfg_is_word(bus.i_cfg_addr);

  // Word registers; a word write never disturbs scheduling state.
  always_ff @(posedge i_avs_clk or posedge i_avs_rst) begin
    if (i_avs_rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) word_q[k] <= 32'd0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (word_wr && (cfg_sel == SLOT_IDX_W'(k))) word_q[k] <= bus.i_cfg_wdata;
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      assign ctl_wr[k] = bus.i_cfg_write && cfg_mapped && cfg_is_ctl(bus.i_cfg_addr)
                         && (cfg_sel == SLOT_IDX_W'(k));
      arinc429_slot_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk_i        (i_avs_clk),
        .rst_i        (i_avs_rst),
        .tick_i       (tick),
        .ctl_wr_i     (ctl_wr[k]),
        .ctl_en_i     (bus.i_cfg_wdata[ENABLE_BIT]),
        .ctl_period_i (bus.i_cfg_wdata[PERIOD_W-1:0]),
        .grant_i      (grant[k]),
        .ovr_clr_i    (bus.i_ovr_clr),
        .pending_o    (pending[k]),
        .overrun_o    (overrun[k])
      );
    end
  endgenerate

  assign bus.o_overrun = overrun;

`ifdef ARINC429_TX_SCHED_APERIODIC_EN
  assign bus.o_apr_ready = (state_q == IDLE) && !i_avs_rst;
  assign apr_take        = bus.i_apr_valid && bus.o_apr_ready;
  assign apr_word        = bus.i_apr_data;
`else
  assign apr_take = 1'b0;
  assign apr_word = 32'd0;
`endif

  // Round-robin pick: rotate pending so bit 0 is rr_q, take the lowest set bit.
  always_comb begin
    any_pend  = |pending;
    pend_rot  = {pending, pending} >> rr_q;
    found     = 1'b0;
    pick      = '0;
    pick_word = 32'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && pend_rot[i]) begin
        found = 1'b1;
        pick  = SLOT_IDX_W'((int'(rr_q) + i) % NUM_SLOTS);
      end else begin
        found = found;
        pick  = pick;
      end
    end
    rr_next = (pick == SLOT_IDX_W'(NUM_SLOTS - 1)) ? '0 : pick + SLOT_IDX_W'(1);
    for (int k = 0; k < NUM_SLOTS; k++) begin
      grant[k]  = (state_q == IDLE) && !apr_take && any_pend && (pick == SLOT_IDX_W'(k));
      pick_word = pick_word | ({32{pick == SLOT_IDX_W'(k)}} & word_q[k]);
    end
  end

  // Grant / hold FSM with registered source outputs.
  always_ff @(posedge i_avs_clk or posedge i_avs_rst) begin
    if (i_avs_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apr_take) begin
            data_q  <= apr_word;
            valid_q <= 1'b1;
            state_q <= SEND;
          end else if (any_pend) begin
            data_q  <= pick_word;
            valid_q <= 1'b1;
            rr_q    <= rr_next;
            state_q <= SEND;
          end else begin
            valid_q <= 1'b0;
          end
        end
        SEND: begin
          if (bus.i_src_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_src_valid = valid_q;
  assign bus.o_src_data  = data_q;

endmodule

// File: tb/tb_arinc429_tx_sched.sv
// Directed and randomized bench for arinc429_tx_sched (TICK_DIV=10, 8 slots).
module tb_arinc429_tx_sched;

  localparam int N  = 8;
  localparam int TD = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arinc429_tx_sched_if #(.NUM_SLOTS(N)) bus ();

  arinc429_tx_sched #(.TICK_DIV(TD), .NUM_SLOTS(N)) dut (
    .i_avs_clk (clk),
    .i_avs_rst (rst),
    .bus       (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc;
  bit          mon_en = 1'b0;
  logic [31:0] obs_q[$];

  bit          t_cfg [N];
  bit          t_en  [N];
  int          t_per [N];
  logic [31:0] t_word[N];

  // Cycles since the last reset release (posedges counted).
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Record every word the transmitter accepts.
  always begin
    @(negedge clk);
    #1;
    if (mon_en && bus.o_src_valid && bus.i_src_ready) obs_q.push_back(bus.o_src_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_cfg_write = 1'b1;
    bus.i_cfg_addr  = a;
    bus.i_cfg_wdata = d;
    @(negedge clk);
    bus.i_cfg_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_cfg_write = 1'b0;
    bus.i_ovr_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Configure from t_* tables, run m ticks, compare against the round-robin reference.
  task automatic run_trial(input int m, input string tag);
    logic [31:0] exp_q[$];
    int p, last;
    bit any;
    do_reset();
    bus.i_src_ready = 1'b1;
    obs_q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < N; k++) if (t_cfg[k]) cfg_wr(5'(2 * k), t_word[k]);
    at_cyc(10);
    for (int k = 0; k < N; k++)
      if (t_cfg[k]) cfg_wr(5'(2 * k + 1), {t_en[k], 15'd0, 16'(t_per[k])});
    at_cyc(10 * m + 20);
    mon_en = 1'b0;
    p = 0;
    for (int n = 1; n <= m; n++) begin
      any = 1'b0;
      last = 0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (p + i) % N;
        if (t_cfg[k] && t_en[k] && t_per[k] != 0 && (n % t_per[k]) == 0) begin
          exp_q.push_back(t_word[k]);
          last = k;
          any = 1'b1;
        end
      end
      if (any) p = (last + 1) % N;
    end
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_word"}, (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    check({tag, "_overrun"}, {24'd0, bus.o_overrun}, 32'd0);
  endtask

  initial begin
    int pulses, errs, act, r;
    bus.i_cfg_write = 1'b0;
    bus.i_cfg_addr  = 5'd0;
    bus.i_cfg_wdata = 32'd0;
    bus.i_ovr_clr   = 1'b0;
    bus.i_src_ready = 1'b0;
`ifdef ARINC429_TX_SCHED_APERIODIC_EN
    bus.i_apr_valid = 1'b0;
    bus.i_apr_data  = 32'd0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, bus.o_src_valid}, 32'd0);
    check("rst_data", bus.o_src_data, 32'd0);
    check("rst_overrun", {24'd0, bus.o_overrun}, 32'd0);
`ifdef ARINC429_TX_SCHED_APERIODIC_EN
    check("rst_apr_ready", {31'd0, bus.o_apr_ready}, 32'd0);
`endif

    // Slot 0, period 3: one word every 30 cycles, first at cycle 31.
    do_reset();
    bus.i_src_ready = 1'b1;
    cfg_wr(5'd0, 32'h0000_00A1);
    cfg_wr(5'd1, 32'h8000_0003);
    pulses = 0;
    errs = 0;
    while (cyc < 100) begin
      if (bus.o_src_valid !== ((cyc == 31) || (cyc == 61) || (cyc == 91))) errs++;
      if (bus.o_src_valid === 1'b1) begin
        pulses++;
        if (bus.o_src_data !== 32'h0000_00A1) errs++;
      end
      @(negedge clk);
    end
    check("p3_pulses", 32'(pulses), 32'd3);
    check("p3_timing", 32'(errs), 32'd0);

    // Slots 0..2, period 2: order 0,1,2 each round.
    for (int k = 0; k < N; k++) begin
      t_cfg[k] = (k < 3);
      t_en[k] = 1'b1;
      t_per[k] = 2;
      t_word[k] = 32'h0000_00B0 + 32'(k);
    end
    run_trial(6, "rr");

    // Overrun with transmitter stalled; word write while slot 0 is being sent.
    do_reset();
    bus.i_src_ready = 1'b0;
    cfg_wr(5'd0, 32'h1111_0000);
    cfg_wr(5'd1, 32'h8000_0001);
    at_cyc(11);
    check("ovr_valid", {31'd0, bus.o_src_valid}, 32'd1);
    check("ovr_data", bus.o_src_data, 32'h1111_0000);
    at_cyc(29);
    check("ovr_before", {31'd0, bus.o_overrun[0]}, 32'd0);
    at_cyc(32);
    cfg_wr(5'd0, 32'h2222_0000);
    check("ovr_hold_data", bus.o_src_data, 32'h1111_0000);
    at_cyc(36);
    check("ovr_hold_valid", {31'd0, bus.o_src_valid}, 32'd1);
    check("ovr_set", {24'd0, bus.o_overrun}, 32'd1);
    bus.i_ovr_clr = 1'b1;
    @(negedge clk);
    bus.i_ovr_clr = 1'b0;
    check("ovr_clr", {24'd0, bus.o_overrun}, 32'd0);
    obs_q.delete();
    mon_en = 1'b1;
    bus.i_src_ready = 1'b1;
    at_cyc(45);
    mon_en = 1'b0;
    check("ovr_n", {31'd0, obs_q.size() >= 2}, 32'd1);
    check("ovr_old_word", (obs_q.size() > 0) ? obs_q[0] : 32'hxxxx_xxxx, 32'h1111_0000);
    check("ovr_new_word", (obs_q.size() > 1) ? obs_q[1] : 32'hxxxx_xxxx, 32'h2222_0000);

    // Control write on the due tick: no word until a full period later.
    do_reset();
    bus.i_src_ready = 1'b1;
    cfg_wr(5'd0, 32'h0000_00C3);
    cfg_wr(5'd1, 32'h8000_0002);
    at_cyc(19);
    cfg_wr(5'd1, 32'h8000_0002);
    pulses = 0;
    while (cyc < 41) begin
      if (bus.o_src_valid !== 1'b0) pulses++;
      @(negedge clk);
    end
    check("cw_quiet", 32'(pulses), 32'd0);
    check("cw_valid", {31'd0, bus.o_src_valid}, 32'd1);
    check("cw_data", bus.o_src_data, 32'h0000_00C3);
    check("cw_overrun", {24'd0, bus.o_overrun}, 32'd0);

`ifdef ARINC429_TX_SCHED_APERIODIC_EN
    // Aperiodic word and pending slot 1 in the same idle cycle.
    do_reset();
    bus.i_src_ready = 1'b1;
    obs_q.delete();
    mon_en = 1'b1;
    cfg_wr(5'd2, 32'h5555_0001);
    cfg_wr(5'd3, 32'h8000_0001);
    at_cyc(10);
    bus.i_apr_valid = 1'b1;
    bus.i_apr_data  = 32'hDEAD_0001;
    @(negedge clk);
    bus.i_apr_valid = 1'b0;
    check("apr_ready_busy", {31'd0, bus.o_apr_ready}, 32'd0);
    at_cyc(16);
    mon_en = 1'b0;
    check("apr_count", 32'(obs_q.size()), 32'd2);
    check("apr_first", (obs_q.size() > 0) ? obs_q[0] : 32'hxxxx_xxxx, 32'hDEAD_0001);
    check("apr_second", (obs_q.size() > 1) ? obs_q[1] : 32'hxxxx_xxxx, 32'h5555_0001);
`endif

    // Randomized slot mixes, at most four active slots so every tick drains.
    for (int t = 0; t < 6; t++) begin
      act = 0;
      for (int k = 0; k < N; k++) begin
        r = int'($urandom_range(0, 3));
        t_cfg[k] = (r != 0);
        t_word[k] = $urandom;
        t_per[k] = int'($urandom_range(1, 4));
        case (r)
          1: begin
            t_en[k] = (act < 4);
            if (act < 4) act++;
          end
          3: begin
            t_en[k] = 1'b1;
            t_per[k] = 0;
          end
          default: t_en[k] = 1'b0;
        endcase
      end
      run_trial(12, "rand");
    end

    // Reset while sending, then unmapped writes: nothing must come out.
    do_reset();
    bus.i_src_ready = 1'b0;
    cfg_wr(5'd4, 32'h3333_0002);
    cfg_wr(5'd5, 32'h8000_0001);
    at_cyc(15);
    check("rs_valid_before", {31'd0, bus.o_src_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid_async", {31'd0, bus.o_src_valid}, 32'd0);
    check("rs_data_async", bus.o_src_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_src_ready = 1'b1;
    cfg_wr(5'd17, 32'h8000_0001);
    cfg_wr(5'd16, 32'hFFFF_FFFF);
    pulses = 0;
    while (cyc < 60) begin
      if (bus.o_src_valid !== 1'b0) pulses++;
      @(negedge clk);
    end
    check("rs_silent", 32'(pulses), 32'd0);
    check("rs_overrun", {24'd0, bus.o_overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
